// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types and constants for the 74HC595 chain controller
//   state_t : shift FSM states (IDLE, SHIFT, LATCH)
//   PWM_W   : width of the brightness / PWM counter
package hc595_pkg;
    localparam int PWM_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
endpackage

// File: rtl/hc595_oe_pwm.sv
// hc595_oe_pwm: free-running PWM that drives the active-low output enable
//   clk    : clock
//   rst    : synchronous active-high reset
//   bright : requested duty in sixteenths, picked up once per PWM period
//   OE     : active-low output enable, low while the counter is below the applied duty
module hc595_oe_pwm
    import hc595_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] bright,
    output logic             OE
);
    logic [PWM_W-1:0] r_p;
    logic [PWM_W-1:0] r_bright;
    // duty is captured on the last count so a new value only takes effect at a period boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p      <= '0;
            r_bright <= '0;
        end else begin
            r_p      <= r_p + 1'b1;
            r_bright <= (&r_p) ? bright : r_bright;
        end
    end
    assign OE = ~(r_p < r_bright);
endmodule

// File: rtl/hc595_chain_ctrl.sv
// hc595_chain_ctrl: serialises a frame into a chain of 74HC595 devices and latches it
//   clk, rst      : clock, synchronous active-high reset
//   data, valid   : frame offer, accepted when valid && ready
//   ready         : high only while idle
//   done          : one-cycle pulse as the frame is latched and the controller returns to idle
//   bright        : output-enable duty in sixteenths
//   shcp, DS      : shift clock and serial data
//   stcp          : storage-register clock
//   OE            : active-low output enable
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int N_CHIPS   = 2,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_CHIPS-1:0]   data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   done,
    input  logic [PWM_W-1:0]       bright,
    output logic                   stcp,
    output logic                   shcp,
    output logic                   DS,
    output logic                   OE
);
    localparam int W  = 8 * N_CHIPS;
    localparam int BW = $clog2(W + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam bit MSB = (MSB_FIRST != 0);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_sh;
    logic [BW-1:0]   r_bit;
    logic [DW-1:0]   r_div;
    logic            r_phase;
    logic            w_tick;
    logic            w_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = valid ? SHIFT : IDLE;
            SHIFT:   w_next = (w_tick && r_phase && w_last) ? LATCH : SHIFT;
            LATCH:   w_next = w_tick ? IDLE : LATCH;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready  = (r_state == IDLE);
        w_tick = (r_div == DIV_LAST);
        w_last = (r_bit == BIT_LAST);
    end

    // r_phase: 0 = shcp-low half of a bit, 1 = shcp-high half; DS only moves at the end of a high half
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            DS      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_sh    <= data;
                        DS      <= MSB ? data[W-1] : data[0];
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_phase <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        r_phase <= ~r_phase;
                        shcp    <= ~r_phase;
                        if (r_phase && w_last) begin
                            stcp <= 1'b1;
                        end else if (r_phase) begin
                            r_bit <= r_bit + 1'b1;
                            r_sh  <= MSB ? (r_sh << 1) : (r_sh >> 1);
                            DS    <= MSB ? r_sh[W-2] : r_sh[1];
                        end
                    end
                end
                LATCH: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_tick) begin
                        stcp <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    hc595_oe_pwm u_pwm (
        .clk    (clk),
        .rst    (rst),
        .bright (bright),
        .OE     (OE)
    );
endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// tb_hc595_chain_ctrl: scoreboard bench for two chain-controller configurations
module tb_hc595_chain_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data0;
    logic        valid0;
    logic [3:0]  bright0;
    logic        ready0, done0, stcp0, shcp0, ds0, oe0;
    logic [7:0]  data1;
    logic        valid1;
    logic [3:0]  bright1;
    logic        ready1, done1, stcp1, shcp1, ds1, oe1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    bit bits0[$], bits1[$];
    int stcp0_q[$], done0_q[$], stcp1_q[$], done1_q[$];
    logic pshcp0 = 0, pstcp0 = 0, pds0 = 0, pshcp1 = 0, pstcp1 = 0, pds1 = 0;

    hc595_chain_ctrl #(.N_CHIPS(2), .CLK_DIV(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0), .done(done0),
        .bright(bright0), .stcp(stcp0), .shcp(shcp0), .DS(ds0), .OE(oe0)
    );
    hc595_chain_ctrl #(.N_CHIPS(1), .CLK_DIV(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1), .ready(ready1), .done(done1),
        .bright(bright1), .stcp(stcp1), .shcp(shcp1), .DS(ds1), .OE(oe1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic oops(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pp();
        return (cyc - base) % 16;
    endfunction

    task automatic send0(input logic [15:0] d, output int t);
        int n = 0;
        valid0 = 1'b1;
        data0  = d;
        while (!ready0 && n < 300) begin
            step();
            n++;
        end
        chk("u0 accept within budget", ready0, 1);
        t = cyc;
        for (int k = 0; k < 16; k++) bits0.push_back(d[15-k]);
        stcp0_q.push_back(t + 65);
        done0_q.push_back(t + 67);
        step();
        valid0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, output int t);
        int n = 0;
        valid1 = 1'b1;
        data1  = d;
        while (!ready1 && n < 300) begin
            step();
            n++;
        end
        chk("u1 accept within budget", ready1, 1);
        t = cyc;
        for (int k = 0; k < 8; k++) bits1.push_back(d[k]);
        stcp1_q.push_back(t + 17);
        done1_q.push_back(t + 18);
        step();
        valid1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (shcp0 && !pshcp0) begin
                if (bits0.size() == 0) oops("u0 unexpected shcp rise");
                else chk("u0 DS at shcp rise", ds0, bits0.pop_front());
            end
            if (shcp0 && ds0 != pds0) oops("u0 DS moved while shcp high");
            if (stcp0 && !pstcp0) begin
                if (stcp0_q.size() == 0) oops("u0 unexpected stcp");
                else chk("u0 stcp rise cycle", cyc, stcp0_q.pop_front());
            end
            if (stcp0 && shcp0) oops("u0 shcp high during stcp");
            if (done0) begin
                if (done0_q.size() == 0) oops("u0 unexpected done");
                else chk("u0 done cycle", cyc, done0_q.pop_front());
                chk("u0 ready with done", ready0, 1);
            end
            if (shcp1 && !pshcp1) begin
                if (bits1.size() == 0) oops("u1 unexpected shcp rise");
                else chk("u1 DS at shcp rise", ds1, bits1.pop_front());
            end
            if (shcp1 && ds1 != pds1) oops("u1 DS moved while shcp high");
            if (stcp1 && !pstcp1) begin
                if (stcp1_q.size() == 0) oops("u1 unexpected stcp");
                else chk("u1 stcp rise cycle", cyc, stcp1_q.pop_front());
            end
            if (stcp1 && shcp1) oops("u1 shcp high during stcp");
            if (done1) begin
                if (done1_q.size() == 0) oops("u1 unexpected done");
                else chk("u1 done cycle", cyc, done1_q.pop_front());
                chk("u1 ready with done", ready1, 1);
            end
        end
        pshcp0 = shcp0; pstcp0 = stcp0; pds0 = ds0;
        pshcp1 = shcp1; pstcp1 = stcp1; pds1 = ds1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb, tc, td, n;
        rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0; bright0 = 4'd0; bright1 = 4'd15;
        repeat (3) step();
        rst  = 1'b0;
        base = cyc;
        chk("reset ready0", ready0, 1);
        chk("reset done0", done0, 0);
        chk("reset shcp0", shcp0, 0);
        chk("reset stcp0", stcp0, 0);
        chk("reset DS0", ds0, 0);
        chk("reset OE0", oe0, 1);
        chk("reset ready1", ready1, 1);
        chk("reset OE1", oe1, 1);
        fork
            begin
                send0(16'hA5C3, ta);
                send0(16'h1234, tb);
                chk("u0 held valid accepted at T+67", tb, ta + 67);
            end
            begin
                send1(8'h01, tc);
                send1(8'h80, td);
                chk("u1 back-to-back accepted at T+18", td, tc + 18);
            end
            begin
                for (int i = 0; i < 32; i++) begin
                    chk("OE0 with bright 0", oe0, 1);
                    step();
                end
                bright0 = 4'd4;
                repeat (16) step();
                for (int i = 0; i < 16; i++) begin
                    chk("OE0 with bright 4", oe0, (pp() < 4) ? 0 : 1);
                    chk("OE1 with bright 15", oe1, (pp() == 15) ? 1 : 0);
                    step();
                end
                for (int i = 0; i < 16; i++) begin
                    if (pp() == 7) bright0 = 4'd9;
                    chk("OE0 keeps bright 4 until period end", oe0, (pp() < 4) ? 0 : 1);
                    step();
                end
                for (int i = 0; i < 16; i++) begin
                    chk("OE0 with bright 9", oe0, (pp() < 9) ? 0 : 1);
                    step();
                end
            end
        join
        n = 0;
        while ((bits0.size() + done0_q.size() + bits1.size() + done1_q.size()) != 0 && n < 300) begin
            step();
            n++;
        end
        chk("scoreboard drained", bits0.size() + done0_q.size() + bits1.size() + done1_q.size(), 0);
        send0(16'hFFFF, ta);
        while (cyc < ta + 20) step();
        chk("u0 DS high before abort", ds0, 1);
        rst    = 1'b1;
        valid0 = 1'b1;
        data0  = 16'h5555;
        step();
        rst    = 1'b0;
        valid0 = 1'b0;
        base   = cyc;
        bits0.delete();
        stcp0_q.delete();
        done0_q.delete();
        chk("abort shcp0", shcp0, 0);
        chk("abort stcp0", stcp0, 0);
        chk("abort DS0", ds0, 0);
        chk("abort ready0 over valid", ready0, 1);
        chk("abort done0", done0, 0);
        repeat (100) step();
        chk("idle after abort", ready0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hc595_chain_ctrl.md
HC595_CHAIN_CTRL -- requirements
Module: hc595_chain_ctrl

Interface
REQ-001 SHALL have parameter N_CHIPS, default 2: number of cascaded 74HC595 devices; W = 8*N_CHIPS shift bits.
REQ-002 SHALL have parameter CLK_DIV, default 2, legal range 1..255: shcp half-period in clk cycles (D).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = data[W-1] shifted first, 0 = data[0] first.
REQ-004 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: data  input  W  frame to load into the chain.
REQ-007 Port: valid  input  1  frame offer; accepted when valid && ready.
REQ-008 Port: ready  output  1  high only in IDLE.
REQ-009 Port: done  output  1  one-cycle pulse when a frame is latched.
REQ-010 Port: bright  input  4  output-enable duty, 0..15 sixteenths.
REQ-011 Port: stcp  output  1  storage-register clock.
REQ-012 Port: shcp  output  1  shift-register clock.
REQ-013 Port: DS  output  1  serial data.
REQ-014 Port: OE  output  1  active-low output enable.

Function
REQ-015 FSM states IDLE, SHIFT, LATCH; IDLE->SHIFT on accept, SHIFT->LATCH after bit W-1 high phase, LATCH->IDLE after D stcp-high cycles.
REQ-016 On accept at cycle T, data SHALL be captured into an internal W-bit register; later data changes have no effect on the frame.
REQ-017 Bit k (0..W-1) SHALL occupy cycles T+1+2kD .. T+2(k+1)D: DS stable throughout, shcp low for the first D cycles, high for the last D.
REQ-018 shcp rising edge therefore SHALL occur D cycles after DS changes; DS SHALL change only while shcp is low.
REQ-019 stcp SHALL be high for cycles T+1+2WD .. T+2WD+D, with shcp low and DS held; low at all other times.
REQ-020 done SHALL pulse for cycle T+2WD+D+1, coincident with return to IDLE and ready=1; a new frame may be accepted that same cycle.
REQ-021 valid while ready=0 SHALL be ignored; no queueing.
REQ-022 In IDLE shcp=0, stcp=0, DS holds last driven value.
REQ-023 Bit counter width SHALL be clog2(W+1); divider counter width clog2(CLK_DIV+1); no wrap before terminal count.
REQ-024 A free-running 4-bit PWM counter p SHALL increment every clk, wrapping 15->0; OE = 0 when p < bright, else 1.
REQ-025 bright SHALL be sampled only when p==15 (applied from p==0), avoiding glitching mid-period.
REQ-026 bright=0 SHALL yield OE constantly 1; bright=15 SHALL yield OE low 15 of every 16 cycles.
REQ-027 PWM SHALL run independent of FSM state; shifting SHALL NOT alter OE.

Reset
REQ-028 rst SHALL force, on the next edge: state IDLE, ready=1, done=0, shcp=0, stcp=0, DS=0, OE=1, p=0, applied bright=0, counters 0.
REQ-029 rst mid-SHIFT or mid-LATCH SHALL abort the frame with no stcp pulse and no done.
REQ-030 rst SHALL take priority over valid in the same cycle.

Structure
REQ-031 Package hc595_pkg SHALL hold the FSM state enum and the PWM width constant (4).
REQ-032 PWM/OE generator SHALL be a sub-module hc595_oe_pwm (ports clk, rst, bright, OE); shift FSM stays in hc595_chain_ctrl.

Verification
REQ-033 N_CHIPS=2, D=2, MSB_FIRST=1, data=16'hA5C3 at T -> DS sampled at 16 shcp rises = 1010010111000011; stcp high T+65..T+66; done at T+67.
REQ-034 Same config, valid held high with new data 16'h1234 during SHIFT -> ignored; shifted frame stays 16'hA5C3; 16'h1234 accepted at T+67.
REQ-035 rst asserted at T+20 -> next cycle shcp=0, stcp=0, DS=0, ready=1; no stcp pulse and no done for that frame.
REQ-036 bright=0 -> OE=1 for 32 cycles; bright=4 -> OE low exactly p=0..3 each period; change bright at p=7 -> takes effect at next p=0.
REQ-037 N_CHIPS=1, D=1, MSB_FIRST=0, data=8'h01 -> first shifted bit 1, then seven 0s; done at T+18; back-to-back frame accepted at T+18.
